arithmetic_logic_unit_system: RTL and testbench
===============================================

ARITHMETIC_LOGIC_UNIT_SYSTEM -- requirements
Module: arithmetic_logic_unit_system

Interface
REQ-001 Parameters: none; fixed 32-bit RF/DR/ALU, 16-bit ARF/IR, 64K x 8 memory.
REQ-002 Clock  in  1  single clock; all state changes on rising edge.
REQ-003 Reset  in  1  synchronous, active-low; sampled on rising Clock.
REQ-004 RF_OutASel, RF_OutBSel  in  3 each  read select: 000..011 R1..R4, 100..111 S1..S4.
REQ-005 RF_FunSel  in  3  RF write function.
REQ-006 RF_RegSel, RF_ScrSel  in  4 each  active-high enables, bit3..bit0 = R1..R4 / S1..S4.
REQ-007 ALU_FunSel  in  5  ALU operation; ALU_WF  in  1  flag write enable.
REQ-008 ARF_OutCSel, ARF_OutDSel  in  2 each  00/01 PC, 10 AR, 11 SP.
REQ-009 ARF_FunSel  in  2; ARF_RegSel  in  3  active-high enables, bit2 PC, bit1 SP, bit0 AR.
REQ-010 IR_LH, IR_Write  in  1 each  IR byte select / write enable.
REQ-011 Mem_CS  in  1  active-low chip select; Mem_WR  in  1  1 write, 0 read.
REQ-012 MuxASel, MuxBSel, MuxCSel  in  2 each; MuxDSel  in  1.
REQ-013 DR_E  in  1  DR enable; DR_FunSel  in  2  DR function.
REQ-014 ALUOut  out  32; FlagsOut  out  4 {Z,C,N,O}.
REQ-015 MuxAOut, MuxBOut, MuxDOut  out  32 each; MuxCOut  out  8.
REQ-016 Address  out  16 (=ARF OutD); MemOut  out  8; IROut  out  16; DROut  out  32.

Function
REQ-017 RF (R1-R4, S1-S4, instances R1..S4 with field Q) input = MuxAOut; each enabled register per RF_FunSel: 000 Q-1, 001 Q+1, 010 load, 011 clear, 100 {24'h0,I[7:0]}, 101 Q[7:0]<=I[7:0], 110 Q[15:0]<=I[15:0], 111 {16{I[15]},I[15:0]}; all arithmetic mod 2^32.
REQ-018 MuxDOut = MuxDSel ? {16'h0,ARF OutC} : RF OutA; ALU A = MuxDOut, ALU B = RF OutB.
REQ-019 ALU_FunSel[4]: 0 16-bit op on [15:0] (result zero-extended, flags from bit15), 1 32-bit op.
REQ-020 ALU_FunSel[3:0]: 0 A, 1 B, 2 ~A, 3 ~B, 4 A+B, 5 A+B+C, 6 A-B, 7 AND, 8 OR, 9 XOR, A NAND, B LSL A, C LSR A, D ASR A, E CSL A (through C), F CSR A (through C).
REQ-021 ALUOut combinational; flags Z (result 0), N (msb), C (carry/borrow/shifted-out bit), O (signed overflow, add/sub only) registered on rising edge only when ALU_WF=1; non-affected flags hold.
REQ-022 MuxA: 00 ALUOut, 01 {16'h0,OutC}, 10 DROut, 11 {24'h0,IROut[7:0]}.
REQ-023 MuxB: 00 ALUOut, 01 {16'h0,OutC}, 10 DROut, 11 {24'h0,IROut[7:0]}; ARF loads MuxBOut[15:0].
REQ-024 ARF (PC, AR, SP, field Q) per ARF_FunSel on enabled regs: 00 Q-1, 01 Q+1, 10 load, 11 clear; mod 2^16.
REQ-025 MuxC: 00 ALUOut[7:0], 01 [15:8], 10 [23:16], 11 [31:24]; memory write data.
REQ-026 Memory RAM_DATA[0:65535] 8-bit; Mem_CS=0,Mem_WR=0: MemOut = RAM_DATA[Address] combinationally; Mem_CS=0,Mem_WR=1: write on rising edge; Mem_CS=1: MemOut=0, no write.
REQ-027 IR (field IROut) when IR_Write=1: IR_LH=0 IROut[7:0]<=MemOut, IR_LH=1 IROut[15:8]<=MemOut; other byte holds.
REQ-028 DR (field DROut) when DR_E=1: 00 clear, 01 {24'h0,MemOut}, 10 {DROut[23:0],MemOut}, 11 {{24{MemOut[7]}},MemOut}.
REQ-029 Simultaneous enables all act in same edge using pre-edge values.

Reset
REQ-030 Reset=0 at rising edge clears all RF, ARF, IR, DR registers and FlagsOut; overrides all enables; memory contents untouched.
REQ-031 Reset=1: normal operation; disabled registers hold.

Verification
REQ-032 R1=77777777, S2=88888887, OutA=000, OutB=101, ALU 10101, WF=1, MuxA/B/C=00, MuxD=0, RegSel=0100, ScrSel=0010, FunSel=010, ARF_RegSel=100, ARF_FunSel=10 -> pre-edge ALUOut=FFFFFFFE, flags 0000, MuxCOut=FE, MuxDOut=77777777; post-edge R2=S3=FFFFFFFE, PC=FFFE, N=1, Z=C=O=0.
REQ-033 RAM[0023]=15, AR=0023, PC=1254, OutC=00, OutD=10, CS=0, WR=0, IR_Write=1, IR_LH=0 -> pre-edge Address=0023, MemOut=15, IROut=0000; post-edge IROut=0015.
REQ-034 R1=FFFFFFFF, S1=1, ALU 10100, WF=1 -> ALUOut=0, after edge Z=1, C=1, O=0.
REQ-035 DR_E=1, FunSel 01 then 10 with MemOut 12 then 34 -> DROut 00000012 then 00001234.
REQ-036 Reset=0 one edge after arbitrary loads -> all registers, flags 0; RAM unchanged.

Source files
------------

// File: rtl/arithmetic_logic_unit_system.sv
// Small datapath: register file, address registers, ALU with flags, 64K x 8 memory, IR and DR,
// joined by the A/B/C/D multiplexers. Everything is clocked on the rising edge with a sync reset.
module arithmetic_logic_unit_system (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [2:0]  RF_OutASel,
  input  logic [2:0]  RF_OutBSel,
  input  logic [2:0]  RF_FunSel,
  input  logic [3:0]  RF_RegSel,
  input  logic [3:0]  RF_ScrSel,
  input  logic [4:0]  ALU_FunSel,
  input  logic        ALU_WF,
  input  logic [1:0]  ARF_OutCSel,
  input  logic [1:0]  ARF_OutDSel,
  input  logic [1:0]  ARF_FunSel,
  input  logic [2:0]  ARF_RegSel,
  input  logic        IR_LH,
  input  logic        IR_Write,
  input  logic        Mem_CS,
  input  logic        Mem_WR,
  input  logic [1:0]  MuxASel,
  input  logic [1:0]  MuxBSel,
  input  logic [1:0]  MuxCSel,
  input  logic        MuxDSel,
  input  logic        DR_E,
  input  logic [1:0]  DR_FunSel,
  output logic [31:0] ALUOut,
  output logic [3:0]  FlagsOut,
  output logic [31:0] MuxAOut,
  output logic [31:0] MuxBOut,
  output logic [31:0] MuxDOut,
  output logic [7:0]  MuxCOut,
  output logic [15:0] Address,
  output logic [7:0]  MemOut,
  output logic [15:0] IROut,
  output logic [31:0] DROut
);

  logic [31:0] rf_r_q [4];
  logic [31:0] rf_s_q [4];
  logic [31:0] rf_out_a, rf_out_b;
  logic [15:0] pc_q, ar_q, sp_q;
  logic [15:0] arf_out_c;
  logic [15:0] ir_q;
  logic [31:0] dr_q;
  logic [3:0]  flags_q;
  logic [7:0]  ram_data [0:65535];

  function automatic logic [31:0] rf_next(input logic [2:0] fs, input logic [31:0] q,
                                          input logic [31:0] d);
    case (fs)
      3'b000:  rf_next = q - 32'd1;
      3'b001:  rf_next = q + 32'd1;
      3'b010:  rf_next = d;
      3'b011:  rf_next = '0;
      3'b100:  rf_next = {24'h0, d[7:0]};
      3'b101:  rf_next = {q[31:8], d[7:0]};
      3'b110:  rf_next = {q[31:16], d[15:0]};
      default: rf_next = {{16{d[15]}}, d[15:0]};
    endcase
  endfunction

  function automatic logic [15:0] arf_next(input logic [1:0] fs, input logic [15:0] q,
                                           input logic [15:0] d);
    case (fs)
      2'b00:   arf_next = q - 16'd1;
      2'b01:   arf_next = q + 16'd1;
      2'b10:   arf_next = d;
      default: arf_next = '0;
    endcase
  endfunction

  // Register file; select bit 3 maps to register index 0 (R1/S1).
  always_comb begin
    rf_out_a = RF_OutASel[2] ? rf_s_q[RF_OutASel[1:0]] : rf_r_q[RF_OutASel[1:0]];
    rf_out_b = RF_OutBSel[2] ? rf_s_q[RF_OutBSel[1:0]] : rf_r_q[RF_OutBSel[1:0]];
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int i = 0; i < 4; i++) begin
        rf_r_q[i] <= '0;
        rf_s_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (RF_RegSel[3-i]) rf_r_q[i] <= rf_next(RF_FunSel, rf_r_q[i], MuxAOut);
        if (RF_ScrSel[3-i]) rf_s_q[i] <= rf_next(RF_FunSel, rf_s_q[i], MuxAOut);
      end
    end
  end

  // Address register file
  always_comb begin
    case (ARF_OutCSel)
      2'b10:   arf_out_c = ar_q;
      2'b11:   arf_out_c = sp_q;
      default: arf_out_c = pc_q;
    endcase
    case (ARF_OutDSel)
      2'b10:   Address = ar_q;
      2'b11:   Address = sp_q;
      default: Address = pc_q;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      pc_q <= '0;
      sp_q <= '0;
      ar_q <= '0;
    end else begin
      if (ARF_RegSel[2]) pc_q <= arf_next(ARF_FunSel, pc_q, MuxBOut[15:0]);
      if (ARF_RegSel[1]) sp_q <= arf_next(ARF_FunSel, sp_q, MuxBOut[15:0]);
      if (ARF_RegSel[0]) ar_q <= arf_next(ARF_FunSel, ar_q, MuxBOut[15:0]);
    end
  end

  // ALU; in 16-bit mode operands are zero-extended so carry/borrow lands in bit 16.
  logic        wide, cin, sa, sb, sr, c_new, o_new, is_arith, is_sub;
  logic [31:0] op_a, op_b, alu_raw, alu_res;
  logic [32:0] sum;

  always_comb begin
    wide     = ALU_FunSel[4];
    cin      = flags_q[2];
    op_a     = wide ? MuxDOut : {16'h0, MuxDOut[15:0]};
    op_b     = wide ? rf_out_b : {16'h0, rf_out_b[15:0]};
    sa       = wide ? op_a[31] : op_a[15];
    sb       = wide ? op_b[31] : op_b[15];
    sum      = '0;
    alu_raw  = '0;
    c_new    = cin;
    is_arith = 1'b0;
    is_sub   = 1'b0;
    case (ALU_FunSel[3:0])
      4'h0: alu_raw = op_a;
      4'h1: alu_raw = op_b;
      4'h2: alu_raw = ~op_a;
      4'h3: alu_raw = ~op_b;
      4'h4: begin
        sum      = {1'b0, op_a} + {1'b0, op_b};
        is_arith = 1'b1;
      end
      4'h5: begin
        sum      = {1'b0, op_a} + {1'b0, op_b} + {32'h0, cin};
        is_arith = 1'b1;
      end
      4'h6: begin
        sum      = {1'b0, op_a} - {1'b0, op_b};
        is_arith = 1'b1;
        is_sub   = 1'b1;
      end
      4'h7: alu_raw = op_a & op_b;
      4'h8: alu_raw = op_a | op_b;
      4'h9: alu_raw = op_a ^ op_b;
      4'hA: alu_raw = ~(op_a & op_b);
      4'hB: begin
        alu_raw = op_a << 1;
        c_new   = sa;
      end
      4'hC: begin
        alu_raw = op_a >> 1;
        c_new   = op_a[0];
      end
      4'hD: begin
        alu_raw = wide ? {op_a[31], op_a[31:1]} : {16'h0, op_a[15], op_a[15:1]};
        c_new   = op_a[0];
      end
      4'hE: begin
        alu_raw = {op_a[30:0], cin};
        c_new   = sa;
      end
      default: begin
        alu_raw = wide ? {cin, op_a[31:1]} : {16'h0, cin, op_a[15:1]};
        c_new   = op_a[0];
      end
    endcase
    if (is_arith) begin
      alu_raw = sum[31:0];
      c_new   = wide ? sum[32] : sum[16];
    end
    alu_res = wide ? alu_raw : {16'h0, alu_raw[15:0]};
    sr      = wide ? alu_res[31] : alu_res[15];
    if (!is_arith) o_new = flags_q[0];
    else if (is_sub) o_new = (sa != sb) && (sr != sa);
    else o_new = (sa == sb) && (sr != sa);
  end

  // Flags packed {Z, C, N, O}
  always_ff @(posedge Clock) begin
    if (!Reset) flags_q <= '0;
    else if (ALU_WF) flags_q <= {(alu_res == 32'h0), c_new, sr, o_new};
  end

  always_comb begin
    ALUOut   = alu_res;
    FlagsOut = flags_q;
    MuxDOut  = MuxDSel ? {16'h0, arf_out_c} : rf_out_a;
    case (MuxASel)
      2'b00:   MuxAOut = alu_res;
      2'b01:   MuxAOut = {16'h0, arf_out_c};
      2'b10:   MuxAOut = dr_q;
      default: MuxAOut = {24'h0, ir_q[7:0]};
    endcase
    case (MuxBSel)
      2'b00:   MuxBOut = alu_res;
      2'b01:   MuxBOut = {16'h0, arf_out_c};
      2'b10:   MuxBOut = dr_q;
      default: MuxBOut = {24'h0, ir_q[7:0]};
    endcase
    case (MuxCSel)
      2'b00:   MuxCOut = alu_res[7:0];
      2'b01:   MuxCOut = alu_res[15:8];
      2'b10:   MuxCOut = alu_res[23:16];
      default: MuxCOut = alu_res[31:24];
    endcase
    MemOut = (!Mem_CS && !Mem_WR) ? ram_data[Address] : 8'h00;
    IROut  = ir_q;
    DROut  = dr_q;
  end

  // Memory is never cleared; reset only blocks writes.
  always_ff @(posedge Clock) begin
    if (Reset && !Mem_CS && Mem_WR) ram_data[Address] <= MuxCOut;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      ir_q <= '0;
      dr_q <= '0;
    end else begin
      if (IR_Write) begin
        if (IR_LH) ir_q[15:8] <= MemOut;
        else ir_q[7:0] <= MemOut;
      end
      if (DR_E) begin
        case (DR_FunSel)
          2'b00:   dr_q <= '0;
          2'b01:   dr_q <= {24'h0, MemOut};
          2'b10:   dr_q <= {dr_q[23:0], MemOut};
          default: dr_q <= {{24{MemOut[7]}}, MemOut};
        endcase
      end
    end
  end

endmodule

// File: tb/tb_arithmetic_logic_unit_system.sv
// Bench for arithmetic_logic_unit_system: ALU vector table through a scoreboard queue, plus
// hand-written sequences for register transfer, memory/IR, DR shifting and reset behaviour.
module tb_arithmetic_logic_unit_system;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
  logic [3:0]  RF_RegSel, RF_ScrSel;
  logic [4:0]  ALU_FunSel;
  logic        ALU_WF;
  logic [1:0]  ARF_OutCSel, ARF_OutDSel, ARF_FunSel;
  logic [2:0]  ARF_RegSel;
  logic        IR_LH, IR_Write, Mem_CS, Mem_WR;
  logic [1:0]  MuxASel, MuxBSel, MuxCSel;
  logic        MuxDSel;
  logic        DR_E;
  logic [1:0]  DR_FunSel;
  logic [31:0] ALUOut, MuxAOut, MuxBOut, MuxDOut, DROut;
  logic [3:0]  FlagsOut;
  logic [7:0]  MuxCOut, MemOut;
  logic [15:0] Address, IROut;

  arithmetic_logic_unit_system dut (
    .Clock(Clock), .Reset(Reset),
    .RF_OutASel(RF_OutASel), .RF_OutBSel(RF_OutBSel), .RF_FunSel(RF_FunSel),
    .RF_RegSel(RF_RegSel), .RF_ScrSel(RF_ScrSel),
    .ALU_FunSel(ALU_FunSel), .ALU_WF(ALU_WF),
    .ARF_OutCSel(ARF_OutCSel), .ARF_OutDSel(ARF_OutDSel), .ARF_FunSel(ARF_FunSel),
    .ARF_RegSel(ARF_RegSel), .IR_LH(IR_LH), .IR_Write(IR_Write),
    .Mem_CS(Mem_CS), .Mem_WR(Mem_WR),
    .MuxASel(MuxASel), .MuxBSel(MuxBSel), .MuxCSel(MuxCSel), .MuxDSel(MuxDSel),
    .DR_E(DR_E), .DR_FunSel(DR_FunSel),
    .ALUOut(ALUOut), .FlagsOut(FlagsOut), .MuxAOut(MuxAOut), .MuxBOut(MuxBOut),
    .MuxDOut(MuxDOut), .MuxCOut(MuxCOut), .Address(Address), .MemOut(MemOut),
    .IROut(IROut), .DROut(DROut)
  );

  initial forever #5 Clock = ~Clock;

  typedef struct {
    logic [4:0]  fun;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  flags;  // {Z,C,N,O} after the edge, starting from all-zero flags
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  flags;
  } exp_t;

  vec_t vecs[17];
  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic idle();
    RF_OutASel = '0; RF_OutBSel = '0; RF_FunSel = '0; RF_RegSel = '0; RF_ScrSel = '0;
    ALU_FunSel = 5'b10000; ALU_WF = 1'b0;
    ARF_OutCSel = '0; ARF_OutDSel = '0; ARF_FunSel = '0; ARF_RegSel = '0;
    IR_LH = 1'b0; IR_Write = 1'b0; Mem_CS = 1'b1; Mem_WR = 1'b0;
    MuxASel = '0; MuxBSel = '0; MuxCSel = '0; MuxDSel = 1'b0;
    DR_E = 1'b0; DR_FunSel = '0;
  endtask

  task automatic do_reset();
    idle();
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
  endtask

  // Build a value in RF register idx (0..3 R1..R4, 4..7 S1..S4) by shift-left and increment.
  task automatic load_rf(input int idx, input logic [31:0] val);
    idle();
    RF_OutASel = 3'(idx);
    if (idx < 4) RF_RegSel = 4'b1000 >> idx;
    else RF_ScrSel = 4'b1000 >> (idx - 4);
    RF_FunSel = 3'b011;
    tick();
    ALU_FunSel = 5'b11011;
    for (int b = 31; b >= 0; b--) begin
      RF_FunSel = 3'b010;
      tick();
      if (val[b]) begin
        RF_FunSel = 3'b001;
        tick();
      end
    end
    idle();
  endtask

  task automatic load_arf(input logic [2:0] sel, input logic [15:0] val);
    load_rf(0, {16'h0, val});
    ALU_FunSel = 5'b10000;
    ARF_RegSel = sel;
    ARF_FunSel = 2'b10;
    tick();
    idle();
  endtask

  task automatic mem_write(input logic [15:0] addr, input logic [7:0] data);
    load_arf(3'b001, addr);
    load_rf(0, {24'h0, data});
    ARF_OutDSel = 2'b10;
    Mem_CS = 1'b0;
    Mem_WR = 1'b1;
    tick();
    idle();
  endtask

  initial begin
    exp_t e;
    vecs[0]  = '{5'b10100, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 4'b1100};
    vecs[1]  = '{5'b10100, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0011};
    vecs[2]  = '{5'b10110, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 4'b0110};
    vecs[3]  = '{5'b10110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 4'b0001};
    vecs[4]  = '{5'b10111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 4'b0010};
    vecs[5]  = '{5'b11001, 32'h12345678, 32'h12345678, 32'h00000000, 4'b1000};
    vecs[6]  = '{5'b11010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 4'b1000};
    vecs[7]  = '{5'b11011, 32'h80000001, 32'h00000000, 32'h00000002, 4'b0100};
    vecs[8]  = '{5'b11100, 32'h00000003, 32'h00000000, 32'h00000001, 4'b0100};
    vecs[9]  = '{5'b11101, 32'h80000000, 32'h00000000, 32'hC0000000, 4'b0010};
    vecs[10] = '{5'b00100, 32'h1234FFFF, 32'h00000001, 32'h00000000, 4'b1100};
    vecs[11] = '{5'b00000, 32'hABCD8000, 32'h00000000, 32'h00008000, 4'b0010};
    vecs[12] = '{5'b10010, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 4'b0010};
    vecs[13] = '{5'b10001, 32'h00000005, 32'h00000000, 32'h00000000, 4'b1000};
    vecs[14] = '{5'b11110, 32'h80000000, 32'h00000000, 32'h00000000, 4'b1100};
    vecs[15] = '{5'b11000, 32'h0000F000, 32'h00000F00, 32'h0000FF00, 4'b0000};
    vecs[16] = '{5'b00110, 32'h00000000, 32'h00000001, 32'h0000FFFF, 4'b0110};

    idle();
    Reset = 1'b0;
    tick();
    tick();
    Reset = 1'b1;
    check("reset_flags", {28'h0, FlagsOut}, 32'h0);
    check("reset_ir", {16'h0, IROut}, 32'h0);
    check("reset_dr", DROut, 32'h0);
    check("reset_pc", {16'h0, Address}, 32'h0);
    check("reset_r1", ALUOut, 32'h0);

    // ALU vector table
    for (int i = 0; i < 17; i++) begin
      do_reset();
      load_rf(0, vecs[i].a);
      load_rf(4, vecs[i].b);
      RF_OutASel = 3'b000;
      RF_OutBSel = 3'b100;
      ALU_FunSel = vecs[i].fun;
      ALU_WF = 1'b1;
      sb_q.push_back('{vecs[i].res, vecs[i].flags});
      #1;
      e = sb_q.pop_front();
      check($sformatf("vec%0d_aluout", i), ALUOut, e.res);
      tick();
      ALU_WF = 1'b0;
      check($sformatf("vec%0d_flags", i), {28'h0, FlagsOut}, {28'h0, e.flags});
    end

    // Simultaneous RF/ARF load from the ALU
    do_reset();
    load_rf(0, 32'h77777777);
    load_rf(5, 32'h88888887);
    RF_OutASel = 3'b000; RF_OutBSel = 3'b101; ALU_FunSel = 5'b10101; ALU_WF = 1'b1;
    RF_RegSel = 4'b0100; RF_ScrSel = 4'b0010; RF_FunSel = 3'b010;
    ARF_RegSel = 3'b100; ARF_FunSel = 2'b10;
    #1;
    check("xfer_pre_alu", ALUOut, 32'hFFFFFFFE);
    check("xfer_pre_flags", {28'h0, FlagsOut}, 32'h0);
    check("xfer_pre_muxc", {24'h0, MuxCOut}, 32'h000000FE);
    check("xfer_pre_muxd", MuxDOut, 32'h77777777);
    tick();
    idle();
    check("xfer_flags", {28'h0, FlagsOut}, 32'h2);
    check("xfer_pc", {16'h0, Address}, 32'h0000FFFE);
    RF_OutASel = 3'b001;
    #1 check("xfer_r2", ALUOut, 32'hFFFFFFFE);
    RF_OutASel = 3'b110;
    #1 check("xfer_s3", ALUOut, 32'hFFFFFFFE);
    RF_OutASel = 3'b000;
    #1 check("xfer_r1_hold", ALUOut, 32'h77777777);

    // Add-with-carry using the carry left by the previous add
    do_reset();
    load_rf(0, 32'hFFFFFFFF);
    load_rf(4, 32'h00000001);
    RF_OutBSel = 3'b100; ALU_FunSel = 5'b10100; ALU_WF = 1'b1;
    tick();
    check("adc_setup_flags", {28'h0, FlagsOut}, 32'hC);
    ALU_FunSel = 5'b10101;
    #1 check("adc_aluout", ALUOut, 32'h00000001);
    tick();
    ALU_WF = 1'b0;
    check("adc_flags", {28'h0, FlagsOut}, 32'h4);

    // Memory write, then instruction fetch into IR
    do_reset();
    mem_write(16'h0023, 8'h15);
    load_arf(3'b100, 16'h1254);
    ARF_OutCSel = 2'b00; ARF_OutDSel = 2'b10; Mem_CS = 1'b0; Mem_WR = 1'b0;
    IR_Write = 1'b1; IR_LH = 1'b0; MuxBSel = 2'b01;
    #1;
    check("ir_pre_addr", {16'h0, Address}, 32'h00000023);
    check("ir_pre_memout", {24'h0, MemOut}, 32'h00000015);
    check("ir_pre_ir", {16'h0, IROut}, 32'h0);
    check("muxb_outc", MuxBOut, 32'h00001254);
    tick();
    check("ir_low", {16'h0, IROut}, 32'h00000015);
    IR_LH = 1'b1;
    tick();
    IR_Write = 1'b0;
    check("ir_high", {16'h0, IROut}, 32'h00001515);
    MuxASel = 2'b11;
    #1 check("muxa_ir", MuxAOut, 32'h00000015);
    Mem_CS = 1'b1;
    #1 check("mem_cs_off", {24'h0, MemOut}, 32'h0);

    // DR loads while AR steps through memory in the same edges
    mem_write(16'h0030, 8'h12);
    mem_write(16'h0031, 8'h34);
    mem_write(16'h0032, 8'h9A);
    load_arf(3'b001, 16'h0030);
    ARF_OutDSel = 2'b10; Mem_CS = 1'b0; DR_E = 1'b1; DR_FunSel = 2'b01;
    ARF_RegSel = 3'b001; ARF_FunSel = 2'b01;
    tick();
    check("dr_load", DROut, 32'h00000012);
    check("dr_ar_inc", {16'h0, Address}, 32'h00000031);
    DR_FunSel = 2'b10;
    tick();
    check("dr_shift", DROut, 32'h00001234);
    DR_FunSel = 2'b11; ARF_RegSel = 3'b000;
    tick();
    check("dr_sext", DROut, 32'hFFFFFF9A);
    MuxASel = 2'b10; DR_E = 1'b0;
    #1 check("muxa_dr", MuxAOut, 32'hFFFFFF9A);
    DR_E = 1'b1; DR_FunSel = 2'b00;
    tick();
    check("dr_clear", DROut, 32'h0);

    // Reset overrides every enable and leaves memory intact
    load_rf(0, 32'h00000023);
    load_rf(6, 32'h0BADF00D);
    RF_OutASel = 3'b000; ALU_FunSel = 5'b10010; ALU_WF = 1'b1;
    ARF_RegSel = 3'b111; ARF_FunSel = 2'b01;
    tick();
    check("pre_reset_flags", {28'h0, FlagsOut}, 32'h2);
    RF_RegSel = 4'b1111; RF_ScrSel = 4'b1111; RF_FunSel = 3'b001;
    DR_E = 1'b1; DR_FunSel = 2'b11; IR_Write = 1'b1; Mem_CS = 1'b0;
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    idle();
    check("rst_flags", {28'h0, FlagsOut}, 32'h0);
    check("rst_ir", {16'h0, IROut}, 32'h0);
    check("rst_dr", DROut, 32'h0);
    for (int d = 0; d < 4; d++) begin
      ARF_OutDSel = 2'(d);
      #1 check($sformatf("rst_arf%0d", d), {16'h0, Address}, 32'h0);
    end
    for (int r = 0; r < 8; r++) begin
      RF_OutASel = 3'(r);
      #1 check($sformatf("rst_rf%0d", r), ALUOut, 32'h0);
    end
    load_arf(3'b001, 16'h0023);
    ARF_OutDSel = 2'b10; Mem_CS = 1'b0;
    #1 check("rst_ram_0023", {24'h0, MemOut}, 32'h00000015);
    load_arf(3'b001, 16'h0031);
    ARF_OutDSel = 2'b10; Mem_CS = 1'b0;
    #1 check("rst_ram_0031", {24'h0, MemOut}, 32'h00000034);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
